// File: rtl/sobel_grad_sq_if.sv
// Pixel-stream bundle for the Sobel gradient stage: raster pixels in, squared
// gradient magnitude (radicand for the sqrt stage) out.
interface sobel_grad_sq_if;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        sof;
    logic [22:0] radicand;
    logic        out_valid;
    logic        out_sof;

    modport master (
        output pix_in, pix_valid, sof,
        input  radicand, out_valid, out_sof
    );

    modport slave (
        input  pix_in, pix_valid, sof,
        output radicand, out_valid, out_sof
    );
endinterface

// File: rtl/sobel_grad_sq.sv
// Streaming 3x3 Sobel stage: two line buffers feed a 3x3 window, and the result
// for centre pixel (r-1,c-1) emerges as Gx^2 + Gy^2 three edges after (r,c).
module sobel_grad_sq #(
    parameter int IMG_WIDTH = 640
) (
    input  logic            clk,
    input  logic            rst,
    sobel_grad_sq_if.slave  bus
);
    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);

    logic          accept;
    logic [CW-1:0] col_reg;
    logic [1:0]    row_reg;
    logic [CW-1:0] cur_col;
    logic [1:0]    cur_row;

    assign accept = bus.pix_valid;

    // sof overrides the counters for the pixel that carries it.
    always_comb begin
        cur_col = col_reg;
        cur_row = row_reg;
        if (bus.sof) begin
            cur_col = '0;
            cur_row = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (accept) begin
            if (cur_col == COL_LAST) begin
                col_reg <= '0;
                row_reg <= (cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1;
            end else begin
                col_reg <= cur_col + CW'(1);
                row_reg <= cur_row;
            end
        end
    end

    // Line buffers with registered read. lb0 takes the old lb1 word one cycle
    // later, from the registered read, so each RAM has one read and one write port.
    logic [7:0]    lb0 [IMG_WIDTH];
    logic [7:0]    lb1 [IMG_WIDTH];
    logic [7:0]    lb0_rd_reg;
    logic [7:0]    lb1_rd_reg;
    logic          v1_reg;
    logic [CW-1:0] wr_col_reg;

    always_ff @(posedge clk) begin
        if (accept) begin
            lb0_rd_reg    <= lb0[cur_col];
            lb1_rd_reg    <= lb1[cur_col];
            lb1[cur_col]  <= bus.pix_in;
        end
        if (v1_reg) begin
            lb0[wr_col_reg] <= lb1_rd_reg;
        end
    end

    // Stage 1: tags for the accepted pixel.
    logic       sof1_reg;
    logic       bord1_reg;
    logic [7:0] pix1_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_reg     <= 1'b0;
            sof1_reg   <= 1'b0;
            bord1_reg  <= 1'b0;
            pix1_reg   <= '0;
            wr_col_reg <= '0;
        end else begin
            v1_reg    <= accept;
            sof1_reg  <= accept & bus.sof;
            bord1_reg <= (cur_row != 2'd2) || (cur_col < CW'(2));
            if (accept) begin
                pix1_reg   <= bus.pix_in;
                wr_col_reg <= cur_col;
            end
        end
    end

    // Stage 2: window shift; row 0 is the oldest line, column 0 the leftmost.
    logic [2:0][7:0]      new_col;
    logic [2:0][2:0][7:0] win;

    assign new_col[0] = lb0_rd_reg;
    assign new_col[1] = lb1_rd_reg;
    assign new_col[2] = pix1_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_win_row
            logic [7:0] w0_reg;
            logic [7:0] w1_reg;
            logic [7:0] w2_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    w0_reg <= '0;
                    w1_reg <= '0;
                    w2_reg <= '0;
                end else if (v1_reg) begin
                    w0_reg <= w1_reg;
                    w1_reg <= w2_reg;
                    w2_reg <= new_col[gi];
                end
            end

            assign win[gi] = {w2_reg, w1_reg, w0_reg};
        end
    endgenerate

    logic v2_reg;
    logic sof2_reg;
    logic bord2_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_reg    <= 1'b0;
            sof2_reg  <= 1'b0;
            bord2_reg <= 1'b0;
        end else begin
            v2_reg    <= v1_reg;
            sof2_reg  <= sof1_reg;
            bord2_reg <= bord1_reg;
        end
    end

    // Stage 3: gradient magnitudes. Only |G| matters once squared.
    logic [9:0] gx_pos, gx_neg, gy_pos, gy_neg;

    assign gx_pos = {2'b0, win[0][2]} + {1'b0, win[1][2], 1'b0} + {2'b0, win[2][2]};
    assign gx_neg = {2'b0, win[0][0]} + {1'b0, win[1][0], 1'b0} + {2'b0, win[2][0]};
    assign gy_pos = {2'b0, win[2][0]} + {1'b0, win[2][1], 1'b0} + {2'b0, win[2][2]};
    assign gy_neg = {2'b0, win[0][0]} + {1'b0, win[0][1], 1'b0} + {2'b0, win[0][2]};

    logic [9:0] gx_mag_reg;
    logic [9:0] gy_mag_reg;
    logic       v3_reg;
    logic       sof3_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gx_mag_reg <= '0;
            gy_mag_reg <= '0;
            v3_reg     <= 1'b0;
            sof3_reg   <= 1'b0;
        end else begin
            v3_reg   <= v2_reg;
            sof3_reg <= sof2_reg;
            if (bord2_reg) begin
                gx_mag_reg <= '0;
                gy_mag_reg <= '0;
            end else begin
                gx_mag_reg <= (gx_pos >= gx_neg) ? gx_pos - gx_neg : gx_neg - gx_pos;
                gy_mag_reg <= (gy_pos >= gy_neg) ? gy_pos - gy_neg : gy_neg - gy_pos;
            end
        end
    end

    // Stage 4: squares and sum (max 2080800, fits 21 bits).
    logic [19:0] sq_x;
    logic [19:0] sq_y;
    logic [20:0] sq_sum;

    assign sq_x   = {10'b0, gx_mag_reg} * {10'b0, gx_mag_reg};
    assign sq_y   = {10'b0, gy_mag_reg} * {10'b0, gy_mag_reg};
    assign sq_sum = {1'b0, sq_x} + {1'b0, sq_y};

    logic [22:0] radicand_reg;
    logic        out_valid_reg;
    logic        out_sof_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            radicand_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_sof_reg   <= 1'b0;
        end else begin
            radicand_reg  <= {2'b0, sq_sum};
            out_valid_reg <= v3_reg;
            out_sof_reg   <= sof3_reg;
        end
    end

    assign bus.radicand  = radicand_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_sof   = out_sof_reg;
endmodule

// File: tb/tb_sobel_grad_sq.sv
// Bench for sobel_grad_sq: frames of structured and random pixels, checked
// cycle by cycle against a whole-image Sobel reference with a 3-cycle delay queue.
module tb_sobel_grad_sq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sobel_grad_sq_if bus ();

    sobel_grad_sq #(.IMG_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit v;
        bit s;
        int rad;
        bit tag;
    } exp_t;

    exp_t q[$];
    int   img[64][W];
    int   mcol, mline;
    int   total = 0;
    int   bad = 0;
    int   npulse, nsof;
    bit   tag_impulse;

    task automatic chk(string tag, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    function automatic int grad(int r, int c);
        int w[3][3];
        int gx, gy;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[i][j] = img[(r - 2 + i) % 64][c - 2 + j];
        gx = (w[0][2] + 2*w[1][2] + w[2][2]) - (w[0][0] + 2*w[1][0] + w[2][0]);
        gy = (w[2][0] + 2*w[2][1] + w[2][2]) - (w[0][0] + 2*w[0][1] + w[0][2]);
        return gx*gx + gy*gy;
    endfunction

    // Reference: absolute image coordinates since the last sof.
    function automatic exp_t model(int p, bit s);
        exp_t e;
        if (s) begin
            mcol  = 0;
            mline = 0;
        end
        img[mline % 64][mcol] = p;
        e.v   = 1'b1;
        e.s   = s;
        e.rad = (mline < 2 || mcol < 2) ? 0 : grad(mline, mcol);
        e.tag = tag_impulse && mline == 2 && mcol == 2;
        mcol++;
        if (mcol == W) begin
            mcol = 0;
            mline++;
        end
        return e;
    endfunction

    function automatic void reset_model();
        exp_t idle;
        idle = '{v: 1'b0, s: 1'b0, rad: 0, tag: 1'b0};
        q.delete();
        repeat (3) q.push_back(idle);
        mcol  = 0;
        mline = 0;
    endfunction

    // Drive one cycle (called just after a negedge) and check the output due now.
    task automatic step(bit v, int p, bit s);
        exp_t e;
        bus.pix_valid = v;
        bus.pix_in    = p[7:0];
        bus.sof       = s;
        if (v) e = model(p, s);
        else   e = '{v: 1'b0, s: 1'b0, rad: 0, tag: 1'b0};
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = q.pop_front();
        chk("out_valid", int'(bus.out_valid), int'(e.v));
        chk("out_sof", int'(bus.out_sof), int'(e.s));
        if (e.v) chk("radicand", int'(bus.radicand), e.rad);
        if (e.tag) chk("impulse22", int'(bus.radicand), 130050);
        if (bus.out_valid) npulse++;
        if (bus.out_sof) nsof++;
    endtask

    function automatic int pix_of(int kind, int r, int c);
        case (kind)
            0:       return 100;
            1:       return (c < 4) ? 0 : 255;
            2:       return (r == 2 && c == 2) ? 255 : 0;
            default: return int'($urandom_range(255));
        endcase
    endfunction

    // Sends up to 'limit' pixels of a frame; gap_pct is the chance of an idle cycle.
    task automatic send_frame(string name, int kind, int rows, int gap_pct, int limit);
        int n = 0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < W; c++) begin
                if (n >= limit) break;
                while (int'($urandom_range(99)) < gap_pct)
                    step(1'b0, int'($urandom_range(255)), 1'($urandom_range(1)));
                step(1'b1, pix_of(kind, r, c), r == 0 && c == 0);
                n++;
            end
        end
        $display("frame %s: kind=%0d rows=%0d pixels=%0d gaps=%0d%%", name, kind, rows, n, gap_pct);
    endtask

    task automatic flush();
        repeat (3) step(1'b0, 0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;
        bus.sof       = 1'b0;
        tag_impulse   = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);
        chk("rst_radicand", int'(bus.radicand), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_sof", int'(bus.out_sof), 0);
        rst = 1'b0;
        @(negedge clk);

        // Flat frame: 32 zero outputs, sof on the first only.
        npulse = 0;
        nsof   = 0;
        send_frame("flat", 0, 4, 0, 1000);
        flush();
        chk("flat_pulses", npulse, 32);
        chk("flat_sofs", nsof, 1);

        send_frame("vstep", 1, 4, 0, 1000);
        flush();

        tag_impulse = 1'b1;
        send_frame("impulse", 2, 5, 0, 1000);
        tag_impulse = 1'b0;
        flush();

        for (int k = 0; k < 3; k++) begin
            npulse = 0;
            send_frame("random_gaps", 3, 6, 30, 1000);
            flush();
            chk("random_pulses", npulse, 6 * W);
        end

        // sof at col 5 of row 3, then a fresh frame.
        send_frame("pre_sof_abort", 3, 4, 10, 3 * W + 5);
        send_frame("after_sof", 3, 6, 10, 1000);
        flush();

        // Reset mid-line: nothing may emerge from the killed pixels.
        send_frame("pre_reset", 3, 4, 0, 2 * W + 3);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", int'(bus.out_valid), 0);
        for (int k = 0; k < 2; k++) begin
            bus.pix_valid = 1'b1;
            bus.pix_in    = 8'($urandom_range(255));
            @(posedge clk);
            @(negedge clk);
            chk("rst_hold_valid", int'(bus.out_valid), 0);
        end
        rst = 1'b0;
        bus.pix_valid = 1'b0;
        reset_model();
        flush();
        send_frame("post_reset", 3, 5, 20, 1000);
        flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
